// File: rtl/syn_c_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : syn_c_ctrl
// Purpose  : Run-control stage for an external synchronous up-counter: arms,
//            runs to a latched limit, and supports one-shot/auto-reload modes.
// Revision : 1.0  initial release
// ============================================================================
module syn_c_ctrl #(
    parameter int REG_SIZE = 4,
    parameter int WRAP_W   = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                reload,
    input  logic [REG_SIZE-1:0] limit,
    input  logic [REG_SIZE-1:0] q,
    output logic                en,
    output logic                cnt_clr,
    output logic                busy,
    output logic                done,
    output logic [WRAP_W-1:0]   wraps
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WRAP_W-1:0] c_wrap_max = '1;

    state_t              state_q,   state_d;
    logic                cnt_clr_q, cnt_clr_d;
    logic                done_q,    done_d;
    logic [WRAP_W-1:0]   wraps_q,   wraps_d;
    logic [REG_SIZE-1:0] limit_q,   limit_d;
    logic                mode_q,    mode_d;
    logic                at_limit;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            wraps_q   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            wraps_q   <= wraps_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        limit_d  = limit_q;
        mode_d   = mode_q;
        wraps_d  = wraps_q;
        done_d   = 1'b0;
        en       = 1'b0;
        at_limit = (q == limit_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ARM;
                    limit_d = limit;
                    mode_d  = reload;
                    wraps_d = '0;
                end
            end
            S_ARM: begin
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                en = !pause && !stop && !at_limit;
                // stop outranks reaching the limit: an aborted run never pulses done
                if (stop) begin
                    state_d = S_IDLE;
                end else if (at_limit) begin
                    done_d  = 1'b1;
                    if (wraps_q != c_wrap_max) begin
                        wraps_d = wraps_q + WRAP_W'(1);
                    end
                    state_d = mode_q ? S_ARM : S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter is held cleared for exactly the ARM cycle.
        cnt_clr_d = (state_d != S_ARM);
    end

    assign cnt_clr = cnt_clr_q;
    assign done    = done_q;
    assign wraps   = wraps_q;
    assign busy    = (state_q == S_ARM) || (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_syn_c_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_c_ctrl
// Purpose  : Directed self-checking bench for syn_c_ctrl with a behavioural
//            up-counter closing the q/en/cnt_clr loop.
// Revision : 1.0  initial release
// ============================================================================
module tb_syn_c_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       reload = 1'b0;
    logic [3:0] limit = 4'd0;

    logic [3:0] q = 4'd0;
    logic       en, cnt_clr, busy, done;
    logic [7:0] wraps;

    logic [3:0] q2 = 4'd0;
    logic       en2, cnt_clr2, busy2, done2;
    logic [1:0] wraps2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    syn_c_ctrl #(.REG_SIZE(4), .WRAP_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause),
        .reload(reload), .limit(limit), .q(q), .en(en), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .wraps(wraps)
    );

    syn_c_ctrl #(.REG_SIZE(4), .WRAP_W(2)) dut2 (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause),
        .reload(reload), .limit(limit), .q(q2), .en(en2), .cnt_clr(cnt_clr2),
        .busy(busy2), .done(done2), .wraps(wraps2)
    );

    // Behavioural up-counters under control of each DUT
    always @(posedge clk) begin
        if (!cnt_clr) q <= 4'd0;
        else if (en)  q <= q + 4'd1;
        if (!cnt_clr2) q2 <= 4'd0;
        else if (en2)  q2 <= q2 + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_en",      32'(en),      32'd0);
            check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
            check("rst_busy",    32'(busy),    32'd0);
            check("rst_done",    32'(done),    32'd0);
            check("rst_wraps",   32'(wraps),   32'd0);
            start  = 1'($urandom);
            stop   = 1'($urandom);
            pause  = 1'($urandom);
            reload = 1'($urandom);
            limit  = 4'($urandom);
        end
        tick();
        check("rst_hold_cnt_clr", 32'(cnt_clr), 32'd0);
        clr = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; reload = 1'b0; limit = 4'd0;
        tick();
        check("rel_cnt_clr", 32'(cnt_clr), 32'd1);
        check("rel_q",       32'(q),       32'd0);
        check("rel_busy",    32'(busy),    32'd0);

        // ---------------- one-shot, limit 5 ----------------
        start = 1'b1; reload = 1'b0; limit = 4'd5;
        tick();
        start = 1'b0;
        check("os_arm_busy",    32'(busy),    32'd1);
        check("os_arm_cnt_clr", 32'(cnt_clr), 32'd0);
        check("os_arm_en",      32'(en),      32'd0);
        for (int i = 0; i <= 5; i++) begin
            tick();
            check("os_q",       32'(q),       32'(i));
            check("os_en",      32'(en),      32'(i != 5));
            check("os_cnt_clr", 32'(cnt_clr), 32'd1);
            check("os_done_lo", 32'(done),    32'd0);
        end
        tick();
        check("os_done",  32'(done),  32'd1);
        check("os_wraps", 32'(wraps), 32'd1);
        check("os_busy",  32'(busy),  32'd0);
        check("os_q_hold", 32'(q),    32'd5);
        check("os_en_off", 32'(en),   32'd0);
        tick();
        check("os_done_pulse", 32'(done), 32'd0);
        check("os_q_hold2",    32'(q),    32'd5);

        // ---------------- auto-reload, limit 3 (period 5) ----------------
        start = 1'b1; reload = 1'b1; limit = 4'd3;
        for (int c = 1; c <= 21; c++) begin
            tick();
            start = 1'b0;
            if ((c - 1) % 5 == 0) begin
                check("ar_arm_cnt_clr", 32'(cnt_clr), 32'd0);
                check("ar_arm_en",      32'(en),      32'd0);
                check("ar_arm_done",    32'(done),    32'(c > 1));
            end else begin
                check("ar_q",        32'(q),       32'((c - 1) % 5 - 1));
                check("ar_en",       32'(en),      32'(((c - 1) % 5 - 1) != 3));
                check("ar_cnt_clr",  32'(cnt_clr), 32'd1);
                check("ar_done_lo",  32'(done),    32'd0);
            end
            check("ar_busy",  32'(busy),  32'd1);
            check("ar_wraps", 32'(wraps), 32'((c - 1) / 5));
        end
        check("ar_wraps2_sat", 32'(wraps2), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ar_stop_busy",  32'(busy),  32'd0);
        check("ar_stop_q",     32'(q),     32'd0);
        check("ar_stop_wraps", 32'(wraps), 32'd4);
        check("ar_stop_done",  32'(done),  32'd0);

        // ---------------- pause then stop, limit 9 ----------------
        start = 1'b1; reload = 1'b0; limit = 4'd9;
        tick();
        start = 1'b0;
        check("ps_arm_cnt_clr", 32'(cnt_clr), 32'd0);
        tick();
        check("ps_q0", 32'(q), 32'd0);
        tick();
        check("ps_q1", 32'(q), 32'd1);
        tick();
        check("ps_q2", 32'(q), 32'd2);
        pause = 1'b1;
        #1;
        check("ps_en_paused", 32'(en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ps_q_hold",  32'(q),  32'd2);
            check("ps_en_hold", 32'(en), 32'd0);
        end
        tick();
        check("ps_q_last", 32'(q), 32'd2);
        pause = 1'b0;
        #1;
        check("ps_en_resume", 32'(en), 32'd1);
        tick();
        check("ps_q3", 32'(q), 32'd3);
        tick();
        check("st_q4", 32'(q), 32'd4);
        stop = 1'b1;
        #1;
        check("st_en_off", 32'(en), 32'd0);
        tick();
        stop = 1'b0;
        check("st_busy",    32'(busy),    32'd0);
        check("st_q_hold",  32'(q),       32'd4);
        check("st_done",    32'(done),    32'd0);
        check("st_cnt_clr", 32'(cnt_clr), 32'd1);
        tick();
        check("st_q_hold2", 32'(q),    32'd4);
        check("st_done2",   32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_arm_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rs_arm_busy",    32'(busy),    32'd1);
        tick();
        check("rs_q0", 32'(q),  32'd0);
        check("rs_en", 32'(en), 32'd1);
        tick();
        check("rs_q1", 32'(q), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("rs_stop_busy", 32'(busy), 32'd0);

        // ---------------- limit 0 one-shot ----------------
        start = 1'b1; reload = 1'b0; limit = 4'd0;
        tick();
        start = 1'b0;
        check("l0_arm_busy", 32'(busy), 32'd1);
        tick();
        check("l0_run_q",    32'(q),    32'd0);
        check("l0_run_en",   32'(en),   32'd0);
        check("l0_run_busy", 32'(busy), 32'd1);
        check("l0_run_done", 32'(done), 32'd0);
        tick();
        check("l0_done",  32'(done),  32'd1);
        check("l0_busy",  32'(busy),  32'd0);
        check("l0_wraps", 32'(wraps), 32'd1);

        // ---------------- wraps saturation, limit 0 auto-reload ----------------
        start = 1'b1; reload = 1'b1; limit = 4'd0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("sat_run_done", 32'(done), 32'd0);
            tick();
            check("sat_done",    32'(done),    32'd1);
            check("sat_cnt_clr", 32'(cnt_clr), 32'd0);
            check("sat_wraps8",  32'(wraps),   32'(k));
            check("sat_wraps2",  32'(wraps2),  32'((k > 3) ? 3 : k));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sat_stop_busy", 32'(busy), 32'd0);

        // ---------------- reset mid-run at the limit ----------------
        start = 1'b1; reload = 1'b0; limit = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("cr_q_at_lim", 32'(q),  32'd2);
        check("cr_en_off",   32'(en), 32'd0);
        clr = 1'b0;
        tick();
        check("cr_done",    32'(done),    32'd0);
        check("cr_busy",    32'(busy),    32'd0);
        check("cr_cnt_clr", 32'(cnt_clr), 32'd0);
        check("cr_wraps",   32'(wraps),   32'd0);
        check("cr_wraps2",  32'(wraps2),  32'd0);
        clr = 1'b1;
        tick();
        check("cr_rel_done",    32'(done),    32'd0);
        check("cr_rel_cnt_clr", 32'(cnt_clr), 32'd1);
        check("cr_rel_q",       32'(q),       32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
